// File: rtl/aq_spsram_ctrl_pkg.sv
// Shared state encoding and default geometry for the 64x58 table-SRAM access controller.
package aq_spsram_ctrl_pkg;

  localparam int AQ_ADDR_WIDTH = 6;
  localparam int AQ_DATA_WIDTH = 58;
  localparam int AQ_WBUF_DEPTH = 2;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/aq_spsram_ctrl_wbuf.sv
// Masked-write buffer: DEPTH-entry FIFO kept in age order (slot 0 oldest) with a per-slot
// index compare so the arbiter can detect or forward read-after-write hits.
module aq_spsram_ctrl_wbuf
  import aq_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = AQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = AQ_DATA_WIDTH,
  parameter int DEPTH      = AQ_WBUF_DEPTH
)(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             push,
  input  logic [ADDR_WIDTH-1:0]            push_idx,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic [DATA_WIDTH-1:0]            push_mask,
  input  logic                             pop,
  input  logic [ADDR_WIDTH-1:0]            cmp_idx,
  output logic                             full,
  output logic                             empty,
  output logic [ADDR_WIDTH-1:0]            head_idx,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic [DATA_WIDTH-1:0]            head_mask,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_data,
  output logic [DEPTH-1:0][DATA_WIDTH-1:0] ent_mask,
  output logic [DEPTH-1:0]                 match
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] mask;
  } entry_t;

  entry_t        ent [DEPTH];
  logic [CW-1:0] cnt;
  logic [CW-1:0] wr_pos;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  // A push lands just behind whatever survives a same-cycle pop.
  assign wr_pos = cnt - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_pos == CW'(i)))
          ent[i] <= {push_idx, push_data, push_mask};
        else if (pop && (i < DEPTH - 1))
          ent[i] <= ent[(i == DEPTH - 1) ? i : i + 1];
      end
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  assign head_idx  = ent[0].idx;
  assign head_data = ent[0].data;
  assign head_mask = ent[0].mask;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_data[i] = ent[i].data;
      ent_mask[i] = ent[i].mask;
      match[i]    = (CW'(i) < cnt) && (ent[i].idx == cmp_idx);
    end
  end

endmodule

// File: rtl/aq_spsram_64x58_ctrl.sv
// Single-port table-SRAM access controller: clear sweep, read/write arbitration, buffered masked writes.
// Build option AQ_SPSRAM_CTRL_FWD_EN: reads hitting buffered writes are forwarded instead of stalled.
module aq_spsram_64x58_ctrl
  import aq_spsram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = AQ_ADDR_WIDTH,
  parameter int DATA_WIDTH = AQ_DATA_WIDTH,
  parameter int WBUF_DEPTH = AQ_WBUF_DEPTH
)(
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  init_busy,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_rdy,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_rdy,
  output logic                  wbuf_empty,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  ctrl_state_t           state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic                  run, hazard, rd_acc, wr_acc, drain;

  logic                                 wb_full, wb_empty;
  logic [ADDR_WIDTH-1:0]                wb_head_idx;
  logic [DATA_WIDTH-1:0]                wb_head_data, wb_head_mask;
  logic [WBUF_DEPTH-1:0][DATA_WIDTH-1:0] wb_ent_data, wb_ent_mask;
  logic [WBUF_DEPTH-1:0]                wb_match;

  logic [DATA_WIDTH-1:0] fwd_mask_n, fwd_data_n, fwd_mask, fwd_data;
  logic [DATA_WIDTH-1:0] rd_merged, rd_hold;

  assign run       = (state == ST_RUN);
  assign init_busy = !run;

`ifdef AQ_SPSRAM_CTRL_FWD_EN
  assign hazard = 1'b0;
`else
  assign hazard = |wb_match;
`endif

  assign rd_rdy     = run & ~inv_req & ~wb_full & ~hazard;
  assign wr_rdy     = run & ~inv_req & ~wb_full;
  assign rd_acc     = rd_vld & rd_rdy;
  assign wr_acc     = wr_vld & wr_rdy;
  // A full buffer forces rd_rdy low, so this also covers the mandatory drain.
  assign drain      = run & ~inv_req & ~wb_empty & ~rd_acc;
  assign wbuf_empty = wb_empty;

  aq_spsram_ctrl_wbuf #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (WBUF_DEPTH)
  ) u_wbuf (
    .clk       (forever_cpuclk),
    .rst_n     (cpurst_b),
    .flush     (inv_req),
    .push      (wr_acc),
    .push_idx  (wr_idx),
    .push_data (wr_data),
    .push_mask (wr_mask),
    .pop       (drain),
    .cmp_idx   (rd_idx),
    .full      (wb_full),
    .empty     (wb_empty),
    .head_idx  (wb_head_idx),
    .head_data (wb_head_data),
    .head_mask (wb_head_mask),
    .ent_data  (wb_ent_data),
    .ent_mask  (wb_ent_mask),
    .match     (wb_match)
  );

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = init_cnt;
    end else if (rd_acc) begin
      sram_cen  = 1'b0;
      sram_a    = rd_idx;
    end else if (drain) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_a    = wb_head_idx;
      sram_d    = wb_head_data;
      sram_wen  = ~wb_head_mask;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state    <= ST_WAIT;
      init_cnt <= '0;
    end else begin
      case (state)
        ST_WAIT: begin
          state    <= ST_INIT;
          init_cnt <= '0;
        end
        ST_INIT: begin
          if (inv_req) begin
            init_cnt <= '0;
          end else if (init_cnt == '1) begin
            state    <= ST_RUN;
            init_cnt <= '0;
          end else begin
            init_cnt <= init_cnt + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (inv_req) begin
            state    <= ST_INIT;
            init_cnt <= '0;
          end
        end
        default: state <= ST_WAIT;
      endcase
    end
  end

  // Oldest-to-youngest merge so younger buffered writes override older ones bitwise.
  always_comb begin
    fwd_mask_n = '0;
    fwd_data_n = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (wb_match[i]) begin
        fwd_data_n = (fwd_data_n & ~wb_ent_mask[i]) | (wb_ent_data[i] & wb_ent_mask[i]);
        fwd_mask_n = fwd_mask_n | wb_ent_mask[i];
      end
    end
  end

  assign rd_merged = (sram_q & ~fwd_mask) | (fwd_data & fwd_mask);
  assign rd_data   = rd_data_vld ? rd_merged : rd_hold;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_data_vld <= 1'b0;
      fwd_mask    <= '0;
      fwd_data    <= '0;
      rd_hold     <= '0;
    end else begin
      rd_data_vld <= rd_acc;
      if (rd_acc) begin
        fwd_mask <= fwd_mask_n;
        fwd_data <= fwd_data_n;
      end
      if (rd_data_vld) rd_hold <= rd_merged;
    end
  end

endmodule

// File: tb/tb_aq_spsram_64x58_ctrl.sv
// Bench for aq_spsram_64x58_ctrl: SRAM model, architectural reference model, directed and random stimulus.
`timescale 1ns/1ps
module tb_aq_spsram_64x58_ctrl;

  localparam int AW = 6;
  localparam int DW = 58;
  localparam int DEPTH = 2;
  localparam int NENT = 64;

  logic          clk = 1'b0;
  logic          rst_b;
  logic          inv_req, init_busy;
  logic          rd_vld, rd_rdy, rd_data_vld, wr_vld, wr_rdy, wbuf_empty;
  logic [AW-1:0] rd_idx, wr_idx, sram_a;
  logic [DW-1:0] rd_data, wr_data, wr_mask, sram_wen, sram_d, sram_q;
  logic          sram_cen, sram_gwen;

  always #5 clk = ~clk;

  aq_spsram_64x58_ctrl dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .inv_req        (inv_req),
    .init_busy      (init_busy),
    .rd_vld         (rd_vld),
    .rd_idx         (rd_idx),
    .rd_rdy         (rd_rdy),
    .rd_data_vld    (rd_data_vld),
    .rd_data        (rd_data),
    .wr_vld         (wr_vld),
    .wr_idx         (wr_idx),
    .wr_data        (wr_data),
    .wr_mask        (wr_mask),
    .wr_rdy         (wr_rdy),
    .wbuf_empty     (wbuf_empty),
    .sram_a         (sram_a),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  // Bit-writable single-port SRAM, read data one cycle after access.
  logic [DW-1:0] mem [NENT];
  initial sram_q = '0;
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= mem[sram_a];
      else for (int b = 0; b < DW; b++) if (!sram_wen[b]) mem[sram_a][b] <= sram_d[b];
    end
  end

  typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; logic [DW-1:0] mask; } wr_t;
  wr_t           pq[$];
  logic [DW-1:0] arch [NENT];
  int            pos;
  bit            chk_en;
  bit            exp_vld;
  logic [DW-1:0] exp_dat, hold_dat;
  int            sweep_wr;
  int            n_tests, n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural table contents plus the queue of accepted-but-unwritten writes.
  always @(negedge clk) begin
    bit run, full, hz, rdy_r, rdy_w, ra, wa, dr;
    logic [DW-1:0] e_wen;
    if (chk_en) begin
      chk("rd_data_vld", rd_data_vld, exp_vld);
      chk("rd_data", rd_data, exp_vld ? exp_dat : hold_dat);
      if (exp_vld) hold_dat = exp_dat;

      run  = (pos == NENT);
      full = (pq.size() == DEPTH);
      hz   = 1'b0;
`ifndef AQ_SPSRAM_CTRL_FWD_EN
      foreach (pq[i]) if (pq[i].idx == rd_idx) hz = 1'b1;
`endif
      rdy_w = run && !inv_req && !full;
      rdy_r = rdy_w && !hz;
      ra    = rd_vld && rdy_r;
      wa    = wr_vld && rdy_w;
      dr    = run && !inv_req && !ra && (pq.size() > 0);

      chk("init_busy", init_busy, !run);
      chk("rd_rdy", rd_rdy, rdy_r);
      chk("wr_rdy", wr_rdy, rdy_w);
      chk("wbuf_empty", wbuf_empty, pq.size() == 0);

      if (!sram_cen && !sram_gwen && (sram_wen == '0) && init_busy) sweep_wr++;

      if (pos >= 0 && pos < NENT) begin
        chk("sweep_cen", sram_cen, 1'b0);
        chk("sweep_gwen", sram_gwen, 1'b0);
        chk("sweep_wen", sram_wen, 64'h0);
        chk("sweep_a", sram_a, pos);
        chk("sweep_d", sram_d, 64'h0);
      end else if (ra) begin
        chk("read_cen", sram_cen, 1'b0);
        chk("read_gwen", sram_gwen, 1'b1);
        chk("read_a", sram_a, rd_idx);
      end else if (dr) begin
        e_wen = ~pq[0].mask;
        chk("drain_cen", sram_cen, 1'b0);
        chk("drain_gwen", sram_gwen, 1'b0);
        chk("drain_a", sram_a, pq[0].idx);
        chk("drain_d", sram_d, pq[0].data);
        chk("drain_wen", sram_wen, e_wen);
      end else begin
        chk("idle_cen", sram_cen, 1'b1);
      end

      exp_vld = ra;
      if (ra) exp_dat = arch[rd_idx];
      if (dr) void'(pq.pop_front());
      if (wa) begin
        arch[wr_idx] = (arch[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
        pq.push_back('{idx: wr_idx, data: wr_data, mask: wr_mask});
      end
      if (inv_req) begin
        pos = 0;
        pq.delete();
        foreach (arch[j]) arch[j] = '0;
      end else if (pos < NENT) begin
        pos++;
      end
    end
  end

  task automatic cyc(input bit rv, input logic [AW-1:0] ri, input bit wv, input logic [AW-1:0] wi,
                     input logic [DW-1:0] wd, input logic [DW-1:0] wm, input bit inv);
    @(posedge clk); #1;
    rd_vld = rv; rd_idx = ri; wr_vld = wv; wr_idx = wi; wr_data = wd; wr_mask = wm; inv_req = inv;
    @(negedge clk); #1;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic do_write(input logic [AW-1:0] idx, input logic [DW-1:0] d, input logic [DW-1:0] m);
    int n = 0;
    cyc(1'b0, '0, 1'b1, idx, d, m, 1'b0);
    while (!wr_rdy && n < 20) begin n++; cyc(1'b0, '0, 1'b1, idx, d, m, 1'b0); end
    chk("wr_accept", wr_rdy, 1'b1);
  endtask

  task automatic do_read(input logic [AW-1:0] idx, output logic [DW-1:0] d, output int stalls);
    stalls = 0;
    cyc(1'b1, idx, 1'b0, '0, '0, '0, 1'b0);
    while (!rd_rdy && stalls < 20) begin stalls++; cyc(1'b1, idx, 1'b0, '0, '0, '0, 1'b0); end
    chk("rd_accept", rd_rdy, 1'b1);
    idle_cyc();
    d = rd_data;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] ones, d;
    logic [63:0]   r1, r2;
    int            st, n;
    ones = '1;
    n_tests = 0; n_fail = 0; sweep_wr = 0;
    chk_en = 1'b0; pos = -1; exp_vld = 1'b0; exp_dat = '0; hold_dat = '0;
    foreach (arch[j]) arch[j] = '0;
    rst_b = 1'b0; inv_req = 0; rd_vld = 0; rd_idx = '0; wr_vld = 0; wr_idx = '0; wr_data = '0; wr_mask = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_busy", init_busy, 1'b1);
    chk("rst_rd_rdy", rd_rdy, 1'b0);
    chk("rst_wr_rdy", wr_rdy, 1'b0);
    chk("rst_rd_data_vld", rd_data_vld, 1'b0);
    chk("rst_rd_data", rd_data, 64'h0);
    chk("rst_wbuf_empty", wbuf_empty, 1'b1);
    chk("rst_cen", sram_cen, 1'b1);
    chk("rst_gwen", sram_gwen, 1'b1);
    chk("rst_wen", sram_wen, ones);
    chk("rst_a", sram_a, 64'h0);
    chk("rst_d", sram_d, 64'h0);

    @(posedge clk); #1;
    rst_b = 1'b1; chk_en = 1'b1;
    @(negedge clk); #1;
    n = 0;
    while (init_busy && n < 300) begin n++; idle_cyc(); end
    chk("busy_cycles_after_reset", n, 65);
    chk("sweep_writes", sweep_wr, 64);

    // Masked write then read-back.
    do_write(6'd5, 58'h3FF, 58'h0FF);
    idle_cyc();
    do_read(6'd5, d, st);
    chk("wr5_readback", d, 58'h0FF);

    // Read hitting a buffered write.
    do_write(6'd9, 58'hAA, 58'hF0);
    do_read(6'd9, d, st);
    chk("rd9_data", d, 58'hA0);
`ifdef AQ_SPSRAM_CTRL_FWD_EN
    chk("rd9_stalls", st, 0);
`else
    chk("rd9_stalls", st, 1);
`endif
    repeat (3) idle_cyc();

    // Same-cycle read and write of one index.
    cyc(1'b1, 6'd3, 1'b1, 6'd3, 58'h1, ones, 1'b0);
    chk("rw3_rd_rdy", rd_rdy, 1'b1);
    chk("rw3_wr_rdy", wr_rdy, 1'b1);
    idle_cyc();
    chk("rw3_old", rd_data, 58'h0);
    do_read(6'd3, d, st);
    chk("rw3_new", d, 58'h1);
    repeat (3) idle_cyc();

    // Reads win until the buffer fills, then one forced drain.
    cyc(1'b1, 6'd30, 1'b1, 6'd20, 58'h5, ones, 1'b0);
    chk("b2b_rdy_1", rd_rdy, 1'b1);
    cyc(1'b1, 6'd31, 1'b1, 6'd21, 58'h6, ones, 1'b0);
    chk("b2b_rdy_2", rd_rdy, 1'b1);
    cyc(1'b1, 6'd32, 1'b0, '0, '0, '0, 1'b0);
    chk("b2b_rdy_full", rd_rdy, 1'b0);
    chk("b2b_drain_gwen", sram_gwen, 1'b0);
    cyc(1'b1, 6'd32, 1'b0, '0, '0, '0, 1'b0);
    chk("b2b_rdy_after", rd_rdy, 1'b1);
    repeat (3) idle_cyc();

    // Invalidate with two buffered writes and a read in flight.
    cyc(1'b1, 6'd7, 1'b1, 6'd40, ones, ones, 1'b0);
    cyc(1'b1, 6'd5, 1'b1, 6'd41, ones, ones, 1'b0);
    cyc(1'b0, '0, 1'b0, '0, '0, '0, 1'b1);
    chk("inv_rd_vld", rd_data_vld, 1'b1);
    chk("inv_rd_data", rd_data, 58'h0FF);
    chk("inv_cen", sram_cen, 1'b1);
    sweep_wr = 0;
    n = 0;
    idle_cyc();
    while (init_busy && n < 300) begin n++; idle_cyc(); end
    chk("busy_cycles_after_inv", n, 64);
    chk("resweep_writes", sweep_wr, 64);
    chk("inv_wbuf_empty", wbuf_empty, 1'b1);
    do_read(6'd40, d, st);
    chk("inv_lost_write", d, 58'h0);
    do_read(6'd5, d, st);
    chk("inv_cleared", d, 58'h0);

    // Random traffic over a narrow index range to provoke hazards.
    for (int k = 0; k < 3000; k++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      cyc($urandom_range(0, 99) < 55, AW'($urandom_range(0, 7)),
          $urandom_range(0, 99) < 55, AW'($urandom_range(0, 7)),
          r1[DW-1:0], r2[DW-1:0], $urandom_range(0, 599) == 0);
    end
    n = 0;
    while ((init_busy || !wbuf_empty) && n < 300) begin n++; idle_cyc(); end
    chk("final_idle", wbuf_empty && !init_busy, 1'b1);
    repeat (2) idle_cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
